// File: rtl/hw_sw_object_table_if.sv
// CPU-side PIO handshake bundle: per-object words, phase code from SW, ack back to SW.
interface hw_sw_object_table_if #(
   parameter int NUM_OBJ = 15
);
   logic [NUM_OBJ*32-1:0] to_hw_port;
   logic [1:0]            to_hw_sig;
   logic [1:0]            to_sw_sig;

   modport master (output to_hw_port, output to_hw_sig, input to_sw_sig);
   modport slave  (input to_hw_port, input to_hw_sig, output to_sw_sig);
endinterface

// File: rtl/hw_sw_object_table.sv
// Object-table receiver: three-phase handshaked capture into a shadow table,
// atomic commit to the active table on frame_sync rise (or immediately).
module hw_sw_object_table #(
   parameter int NUM_OBJ         = 15,
   parameter int COORD_W         = 10,
   parameter int FIELD_W         = 3,
   parameter int Y_MAX           = 480,
   parameter int Y_FLIP          = 1,
   parameter int COMMIT_ON_VSYNC = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   hw_sw_object_table_if.slave          bus,
   input  logic                         frame_sync,
   output logic [NUM_OBJ*COORD_W-1:0]   x_coord,
   output logic [NUM_OBJ*COORD_W-1:0]   y_coord,
   output logic [NUM_OBJ*FIELD_W-1:0]   obj_state,
   output logic [NUM_OBJ*FIELD_W-1:0]   obj_type,
   output logic                         table_valid,
   output logic [7:0]                   frame_count,
   output logic                         proto_err
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             sig_q, cur_q, ack_q;
   logic [NUM_OBJ*32-1:0]  port_q;
   logic [2:0]             mask_q, cap_bit;
   logic                   pend_q, fs_q;
   logic                   cap_en, err_set, commit, fs_rise;

   assign bus.to_sw_sig = ack_q;
   assign fs_rise       = frame_sync & ~fs_q;
   assign commit        = pend_q & ((COMMIT_ON_VSYNC == 0) | fs_rise);
   assign cap_bit       = 3'b001 << (sig_q - 2'd1);

   always_comb begin
      state_d = state_q;
      cap_en  = 1'b0;
      err_set = 1'b0;
      case (state_q)
         IDLE: if (sig_q != 2'd0) begin
            cap_en  = 1'b1;
            state_d = ACK;
         end
         ACK: begin
            if (sig_q == 2'd0)       state_d = IDLE;
            else if (sig_q != cur_q) err_set = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sig_q       <= '0;
         port_q      <= '0;
         fs_q        <= 1'b0;
         cur_q       <= '0;
         ack_q       <= '0;
         mask_q      <= '0;
         pend_q      <= 1'b0;
         table_valid <= 1'b0;
         frame_count <= '0;
         proto_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= bus.to_hw_sig;
         port_q  <= bus.to_hw_port;
         fs_q    <= frame_sync;
         if (cap_en) begin
            cur_q <= sig_q;
            ack_q <= sig_q;
         end else if (state_q == ACK && sig_q == 2'd0) begin
            ack_q <= '0;
         end
         if (err_set) proto_err <= 1'b1;
         // A capture coinciding with commit starts the next table with just its own bit.
         if (commit)      mask_q <= cap_en ? cap_bit : 3'b000;
         else if (cap_en) mask_q <= mask_q | cap_bit;
         if (commit)                                   pend_q <= 1'b0;
         else if (mask_q == 3'b111 && state_q == IDLE) pend_q <= 1'b1;
         if (commit) begin
            table_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      logic [31:0]        w;
      logic               unused_hi;
      logic [COORD_W-1:0] y_new;
      logic [COORD_W-1:0] sh_x, sh_y, act_x, act_y;
      logic [FIELD_W-1:0] sh_st, sh_ty, act_st, act_ty;

      assign w         = port_q[32*i +: 32];
      assign unused_hi = ^w;
      assign y_new     = (Y_FLIP != 0) ? COORD_W'(Y_MAX) - w[COORD_W-1:0] : w[COORD_W-1:0];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_st  <= '0;
            sh_ty  <= '0;
            act_x  <= '0;
            act_y  <= '0;
            act_st <= '0;
            act_ty <= '0;
         end else begin
            // Commit reads the pre-capture shadow through non-blocking semantics.
            if (commit) begin
               act_x  <= sh_x;
               act_y  <= sh_y;
               act_st <= sh_st;
               act_ty <= sh_ty;
            end
            if (cap_en) begin
               case (sig_q)
                  2'd1: sh_x <= w[COORD_W-1:0];
                  2'd2: sh_y <= y_new;
                  2'd3: begin
                     sh_st <= w[FIELD_W-1:0];
                     sh_ty <= w[2*FIELD_W-1:FIELD_W];
                  end
                  default: ;
               endcase
            end
         end
      end

      assign x_coord[i*COORD_W +: COORD_W]   = act_x;
      assign y_coord[i*COORD_W +: COORD_W]   = act_y;
      assign obj_state[i*FIELD_W +: FIELD_W] = act_st;
      assign obj_type[i*FIELD_W +: FIELD_W]  = act_ty;
   end

endmodule

// File: tb/tb_hw_sw_object_table.sv
// Random + directed bench for hw_sw_object_table with a transaction-level table model.
module tb_hw_sw_object_table;
   localparam int N  = 15;
   localparam int CW = 10;
   localparam int FW = 3;

   logic clk = 1'b0, reset = 1'b0, frame_sync = 1'b0;
   logic [N*CW-1:0] x_coord, y_coord;
   logic [N*FW-1:0] obj_state, obj_type;
   logic            table_valid, proto_err;
   logic [7:0]      frame_count;
   logic [31:0]     words [N];

   int n_vec = 0, n_err = 0;

   hw_sw_object_table_if #(.NUM_OBJ(N)) bus ();

   hw_sw_object_table #(.NUM_OBJ(N), .COORD_W(CW), .FIELD_W(FW), .Y_MAX(480),
                        .Y_FLIP(1), .COMMIT_ON_VSYNC(1)) dut (
      .clk(clk), .reset(reset), .bus(bus), .frame_sync(frame_sync),
      .x_coord(x_coord), .y_coord(y_coord), .obj_state(obj_state), .obj_type(obj_type),
      .table_valid(table_valid), .frame_count(frame_count), .proto_err(proto_err));

   always #5 clk = ~clk;

   always_comb begin
      bus.to_hw_port = '0;
      for (int i = 0; i < N; i++) bus.to_hw_port[32*i +: 32] = words[i];
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (table-level, phase tracked as "busy/cur") ----
   int  ax[N], ay[N], ast[N], aty[N];   // active
   int  sx[N], sy[N], sst[N], sty[N];   // shadow
   bit  have [1:3];
   bit  m_pend = 0, m_busy = 0, m_err = 0, m_valid = 0, m_fs = 0;
   int  m_cur = 0, m_ack = 0, m_cnt = 0, m_sq = 0;
   logic [31:0] m_pw [N];

   function automatic int flip_y(input logic [31:0] p);
      return ((480 - int'(p[9:0])) % 1024 + 1024) % 1024;
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         ax[i] = 0; ay[i] = 0; ast[i] = 0; aty[i] = 0;
         sx[i] = 0; sy[i] = 0; sst[i] = 0; sty[i] = 0; m_pw[i] = 0;
      end
      for (int c = 1; c <= 3; c++) have[c] = 0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int i = 0; i < N; i++) begin
               ax[i] = 0; ay[i] = 0; ast[i] = 0; aty[i] = 0;
               sx[i] = 0; sy[i] = 0; sst[i] = 0; sty[i] = 0; m_pw[i] = 0;
            end
            for (int c = 1; c <= 3; c++) have[c] = 0;
            m_pend = 0; m_busy = 0; m_err = 0; m_valid = 0; m_fs = 0;
            m_cur = 0; m_ack = 0; m_cnt = 0; m_sq = 0;
         end else begin
            bit cm, cap, np, full;
            full = have[1] && have[2] && have[3];
            cm   = m_pend && frame_sync && !m_fs;
            cap  = !m_busy && m_sq != 0;
            np   = cm ? 1'b0 : (m_pend || (full && !m_busy));
            if (cm) begin
               ax = sx; ay = sy; ast = sst; aty = sty;
               m_valid = 1; m_cnt = (m_cnt + 1) % 256;
               for (int c = 1; c <= 3; c++) have[c] = 0;
            end
            m_pend = np;
            if (cap) begin
               have[m_sq] = 1;
               for (int i = 0; i < N; i++) begin
                  if (m_sq == 1) sx[i] = int'(m_pw[i][9:0]);
                  if (m_sq == 2) sy[i] = flip_y(m_pw[i]);
                  if (m_sq == 3) begin sst[i] = m_pw[i] % 8; sty[i] = (m_pw[i] / 8) % 8; end
               end
               m_busy = 1; m_cur = m_sq; m_ack = m_sq;
            end else if (m_busy) begin
               if (m_sq == 0) begin m_busy = 0; m_ack = 0; end
               else if (m_sq != m_cur) m_err = 1;
            end
            m_sq = int'(bus.to_hw_sig);
            m_pw = words;
            m_fs = frame_sync;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      begin
         logic [N*CW-1:0] ex, ey;
         logic [N*FW-1:0] es, et;
         for (int i = 0; i < N; i++) begin
            ex[i*CW +: CW] = CW'(ax[i]);
            ey[i*CW +: CW] = CW'(ay[i]);
            es[i*FW +: FW] = FW'(ast[i]);
            et[i*FW +: FW] = FW'(aty[i]);
         end
         chk("to_sw_sig", 256'(bus.to_sw_sig), 256'(m_ack));
         chk("x_coord", 256'(x_coord), 256'(ex));
         chk("y_coord", 256'(y_coord), 256'(ey));
         chk("obj_state", 256'(obj_state), 256'(es));
         chk("obj_type", 256'(obj_type), 256'(et));
         chk("table_valid", 256'(table_valid), 256'(m_valid));
         chk("frame_count", 256'(frame_count), 256'(m_cnt));
         chk("proto_err", 256'(proto_err), 256'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack(input int c);
      int k = 0;
      while (bus.to_sw_sig != 2'(c) && k < 20) begin tick(); k++; end
      if (bus.to_sw_sig != 2'(c)) chk("ack_wait", 256'(bus.to_sw_sig), 256'(c));
   endtask

   task automatic phase(input int c);
      bus.to_hw_sig = 2'(c);
      wait_ack(c);
      bus.to_hw_sig = 2'd0;
      wait_ack(0);
   endtask

   task automatic rand_words();
      for (int i = 0; i < N; i++) words[i] = $urandom;
   endtask

   task automatic load_all();
      for (int c = 1; c <= 3; c++) begin rand_words(); phase(c); end
   endtask

   task automatic fs_pulse();
      tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
   endtask

   function automatic int xo(input int i); return int'(x_coord[i*CW +: CW]); endfunction
   function automatic int yo(input int i); return int'(y_coord[i*CW +: CW]); endfunction

   initial begin
      int cnt0, old_x;
      bus.to_hw_sig = 2'd0;
      for (int i = 0; i < N; i++) words[i] = '0;
      tick(2);
      chk("rst_valid", 256'(table_valid), 256'(0));
      chk("rst_count", 256'(frame_count), 256'(0));
      reset = 1'b1;
      tick(2);

      // Test 1: obj1 X=100, Y=50, state=2 type=5
      rand_words(); words[1] = 32'd100; phase(1);
      rand_words(); words[1] = 32'd50;  phase(2);
      rand_words(); words[1] = 32'd42;  phase(3);
      fs_pulse();
      chk("t1_x", 256'(xo(1)), 256'(100));
      chk("t1_y", 256'(yo(1)), 256'(430));
      chk("t1_state", 256'(obj_state[FW +: FW]), 256'(2));
      chk("t1_type", 256'(obj_type[FW +: FW]), 256'(5));
      chk("t1_count", 256'(frame_count), 256'(1));

      // Test 2: complete table without vsync holds outputs
      load_all();
      tick(5);
      chk("t2_hold_x", 256'(xo(1)), 256'(100));
      chk("t2_hold_count", 256'(frame_count), 256'(1));
      fs_pulse();
      chk("t2_count", 256'(frame_count), 256'(2));

      // Test 4: y wrap
      rand_words(); phase(1);
      rand_words(); words[0] = 32'd500; phase(2);
      rand_words(); phase(3);
      fs_pulse();
      chk("t4_y_wrap", 256'(yo(0)), 256'(1004));

      // Test 3: protocol error 1 -> 2 without 0
      chk("t3_err_before", 256'(proto_err), 256'(0));
      rand_words();
      bus.to_hw_sig = 2'd1; wait_ack(1);
      rand_words();
      bus.to_hw_sig = 2'd2; tick(4);
      chk("t3_err", 256'(proto_err), 256'(1));
      chk("t3_ack_hold", 256'(bus.to_sw_sig), 256'(1));
      bus.to_hw_sig = 2'd0; wait_ack(0);
      chk("t3_ack_idle", 256'(bus.to_sw_sig), 256'(0));

      // Test 6: capture coincides with vsync commit
      for (int i = 0; i < N; i++) words[i] = 32'(i + 7);
      phase(1);
      load_all();
      load_all();
      rand_words(); words[1] = 32'd321; phase(1);
      rand_words(); phase(2); rand_words(); phase(3);
      tick(2);
      cnt0 = int'(frame_count);
      old_x = 321;
      rand_words(); words[1] = 32'd77;
      bus.to_hw_sig = 2'd1;
      tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("t6_count", 256'(frame_count), 256'((cnt0 + 1) % 256));
      chk("t6_old_x", 256'(xo(1)), 256'(old_x));
      wait_ack(1);
      bus.to_hw_sig = 2'd0; wait_ack(0);
      fs_pulse();
      chk("t6_no_commit", 256'(frame_count), 256'((cnt0 + 1) % 256));
      rand_words(); phase(2); rand_words(); phase(3);
      fs_pulse();
      chk("t6_new_x", 256'(xo(1)), 256'(77));

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         int r, a, b;
         r = $urandom_range(0, 9);
         if (r < 7) begin
            rand_words(); phase($urandom_range(1, 3));
         end else if (r < 9) begin
            fs_pulse();
         end else begin
            a = $urandom_range(1, 3);
            b = (a % 3) + 1;
            rand_words(); bus.to_hw_sig = 2'(a); wait_ack(a);
            rand_words(); bus.to_hw_sig = 2'(b); tick($urandom_range(1, 3));
            bus.to_hw_sig = 2'd0; wait_ack(0);
         end
      end

      // Test 5: reset during handshake
      rand_words();
      bus.to_hw_sig = 2'd2; wait_ack(2);
      #2 reset = 1'b0;
      #1;
      chk("t5_ack", 256'(bus.to_sw_sig), 256'(0));
      chk("t5_x", 256'(x_coord), 256'(0));
      chk("t5_valid", 256'(table_valid), 256'(0));
      chk("t5_count", 256'(frame_count), 256'(0));
      chk("t5_err", 256'(proto_err), 256'(0));
      bus.to_hw_sig = 2'd0;
      tick(2);
      reset = 1'b1;
      tick();
      fs_pulse();
      chk("t5_still_invalid", 256'(table_valid), 256'(0));
      load_all();
      fs_pulse();
      chk("t5_valid_after", 256'(table_valid), 256'(1));
      chk("t5_count_after", 256'(frame_count), 256'(1));
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
